// File: rtl/pc_select_ras.sv
// Registered next-PC generator for fetch: fixed-priority redirect selection plus a
// return-address stack that learns call/return pairs from rename.
module pc_select_ras #(
    parameter int unsigned WIDTH     = 31,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mispredict,
    input  logic [WIDTH:0] seqPC,
    input  logic           misdirect,
    input  logic [WIDTH:0] targetAddress,
    input  logic           isJAL,
    input  logic [WIDTH:0] validAddress,
    input  logic           isCall,
    input  logic [WIDTH:0] callPC,
    input  logic           isRet,
    input  logic           predictorHit,
    input  logic [WIDTH:0] predictedPC,
    input  logic           freeze,
    output logic [WIDTH:0] nextPC,
    output logic           redirect,
    output logic           rasHit
);

    localparam int unsigned    PtrW   = $clog2(RAS_DEPTH);
    localparam logic [WIDTH:0] StepW  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] OneW   = (WIDTH + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW:0]  CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW:0]  CntMax = (PtrW + 1)'(RAS_DEPTH);

    logic [WIDTH:0]  ras_mem [RAS_DEPTH];
    logic [PtrW-1:0] tp_q, tp_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic [WIDTH:0]  pc_d;
    logic            redirect_d, ras_hit_d;
    logic            flush, push, pop, update;

    always_comb begin
        flush      = mispredict | misdirect;
        push       = !flush && isJAL && isCall;
        pop        = !flush && !isJAL && isRet && (cnt_q != '0);
        // A flush must land even while fetch is stalled.
        update     = flush || !freeze;
        pc_d       = nextPC + StepW;
        redirect_d = 1'b0;
        ras_hit_d  = 1'b0;
        tp_d       = tp_q;
        cnt_d      = cnt_q;

        if (mispredict) begin
            pc_d = seqPC;
        end else if (misdirect) begin
            pc_d = targetAddress;
        end else if (isJAL) begin
            pc_d = validAddress;
        end else if (pop) begin
            pc_d      = ras_mem[tp_q];
            ras_hit_d = 1'b1;
        end else if (predictorHit) begin
            pc_d       = predictedPC;
            redirect_d = 1'b1;
        end

        if (flush) begin
            tp_d  = '0;
            cnt_d = '0;
        end else if (push) begin
            tp_d = tp_q + PtrOne;
            // Saturating count: a push while full silently drops the oldest entry.
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (pop) begin
            tp_d  = tp_q - PtrOne;
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nextPC   <= '0;
            redirect <= 1'b0;
            rasHit   <= 1'b0;
            tp_q     <= '0;
            cnt_q    <= '0;
        end else if (update) begin
            nextPC   <= pc_d;
            redirect <= redirect_d;
            rasHit   <= ras_hit_d;
            tp_q     <= tp_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (update && push) begin
            ras_mem[tp_q + PtrOne] <= callPC + OneW;
        end
    end

endmodule

// File: doc/pc_select_ras.md
# pc_select_ras

Registered next-PC generator for the fetch stage, replacing the single-step priority selector with a parametrised version. It takes redirect requests from commit (mispredict, misdirect), rename (JAL), a new return-address stack (RAS), and the branch predictor. Each cycle it picks one next-fetch PC by fixed priority and registers it. The RAS learns call/return pairs from rename, so returns redirect fetch without waiting for the branch target buffer.

## Interface
Parameters:
- WIDTH, 31, MSB index of every PC; all PC buses are WIDTH+1 bits
- STEP, 1, sequential increment in words (instruction memory is word addressed)
- RAS_DEPTH, 8, number of RAS entries; must be a power of two, at least 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- mispredict  input  1  commit-stage mispredict; flush source
- seqPC  input  WIDTH+1  restart PC used on mispredict
- misdirect  input  1  commit-stage misdirect; flush source
- targetAddress  input  WIDTH+1  restart PC used on misdirect
- isJAL  input  1  rename stage holds a JAL
- validAddress  input  WIDTH+1  JAL target
- isCall  input  1  qualifies isJAL: the JAL writes the link register, so push onto the RAS
- callPC  input  WIDTH+1  PC of the calling JAL
- isRet  input  1  decode flags a return (JALR through the link register)
- predictorHit  input  1  branch target buffer hit
- predictedPC  input  WIDTH+1  branch target buffer target
- freeze  input  1  fetch stall
- nextPC  output  WIDTH+1  registered fetch PC
- redirect  output  1  registered; nextPC came from predictorHit
- rasHit  output  1  registered; nextPC came from the RAS

## Operation
Source priority, highest first:
1. mispredict: seqPC
2. misdirect: targetAddress
3. isJAL: validAddress
4. isRet with RAS count>0: RAS top
5. predictorHit: predictedPC
6. Otherwise: nextPC + STEP

Sequential arithmetic:
- nextPC + STEP is computed modulo 2^(WIDTH+1); it wraps silently.

RAS storage:
- Circular array, a top pointer tp, and a count that saturates at RAS_DEPTH.
- Push (source 3 selected with isCall=1): write callPC+1 (modulo 2^(WIDTH+1)) at tp+1, then tp++ and count=min(count+1, RAS_DEPTH).
- A push while full overwrites the oldest entry.
- Pop (source 4 selected): read entry[tp], then tp-- and count--.
- isRet with count=0 has no effect; selection falls through to source 5 or 6.
- Flush (mispredict or misdirect): tp=0, count=0. Entry contents are don't-care.

Effect of each input:
- An input has effect only when its source is the one selected. For example, isCall with isJAL=0 is ignored, and isRet is ignored whenever isJAL=1.

Freeze:
- With freeze=1 and no flush, nextPC, redirect, rasHit and the RAS hold.
- A flush overrides freeze: nextPC loads the flush PC and the RAS clears.

Output flags:
- redirect=1 only when source 5 is selected.
- rasHit=1 only when source 4 is selected.
- Both flags are 0 for every other source.

## Timing
- Selection is combinational.
- nextPC, redirect, rasHit and the RAS state update on the same clk edge, so latency from request to nextPC is 1 cycle.
- redirect and rasHit are aligned with the nextPC they describe.
- Reset values (asynchronous): nextPC=0, redirect=0, rasHit=0, tp=0, count=0.
- Deasserting reset mid-operation resumes from PC 0 with an empty RAS.
- A push and a pop never happen in the same cycle, because priority selects exactly one source.
- A pop in the cycle immediately after a push returns the just-pushed value.

## Test plan
- Sequential fetch and wrap:
  - Reset, then idle with STEP=1 → nextPC sequence 0,1,2,3 and redirect=rasHit=0.
  - Force nextPC=0xFFFFFFFF → next value is 0.
- Priority collision:
  - mispredict, misdirect, isJAL and predictorHit all asserted, seqPC=0x40 → nextPC=0x40, redirect=0.
  - Drop mispredict → nextPC=targetAddress.
- Call/return:
  - isJAL=isCall=1, callPC=0x100, validAddress=0x200 → nextPC=0x200.
  - Next cycle isRet=1 → nextPC=0x101, rasHit=1.
  - isRet again with the RAS empty and predictorHit=1, predictedPC=0x300 → nextPC=0x300, redirect=1.
- Overflow (RAS_DEPTH=8):
  - 9 calls with callPC=0x10..0x18, then 9 returns.
  - The first 8 returns yield 0x19 down to 0x12 with rasHit=1.
  - The 9th return falls through to sequential with rasHit=0.
- Freeze and flush:
  - freeze=1 for 3 cycles with isJAL=1 → nextPC and RAS unchanged.
  - freeze=1 with misdirect=1, targetAddress=0x80 → nextPC=0x80 and RAS count=0 (a following isRet gives rasHit=0).
- Asynchronous reset mid-stream:
  - Assert reset between edges after 3 calls → outputs go to 0 immediately.
  - After release, isRet gives rasHit=0 and nextPC=1.
